// File: rtl/banner_scan_ctrl_if.sv
// Purpose : ROM address/data bus plus pixel valid/ready stream of the banner scanner.
// Latency : none (wires only); the ROM answers one cycle after rom_addr.
// Backpr. : pix_valid & !pix_ready stalls the stream; the master holds pix_* stable.
//
// Signals (master = banner_scan_ctrl):
//   rom_addr  master->ROM   row address
//   rom_data  ROM->master   row word, valid the cycle after rom_addr
//   pix_valid master->sink  pixel valid
//   pix_ready sink->master  pixel accepted (transfer = valid & ready)
//   pix_on    master->sink  pixel value
//   pix_row   master->sink  row of the pixel
//   pix_col   master->sink  screen column of the pixel
interface banner_scan_ctrl_if #(
    parameter int WIDTH = 71,
    parameter int AW    = 5,
    parameter int CW    = 7
);
    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_on;
    logic [AW-1:0]    pix_row;
    logic [CW-1:0]    pix_col;

    modport master (
        output rom_addr,
        output pix_valid,
        output pix_on,
        output pix_row,
        output pix_col,
        input  rom_data,
        input  pix_ready
    );

    modport slave (
        input  rom_addr,
        input  pix_valid,
        input  pix_on,
        input  pix_row,
        input  pix_col,
        output rom_data,
        output pix_ready
    );
endinterface

// File: rtl/banner_scan_ctrl.sv
// Purpose : scans ROWS banner ROM rows per frame and streams them as a scrolling pixel stream.
// Latency : first pixel 3 cycles after start; ROWS*(WIDTH+2) cycles to last pixel, then 1 DONE cycle.
// Backpr. : while pix_valid & !pix_ready every pix_* output is held; no pixel is skipped.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_start         begin one frame (sampled in IDLE only)
//   o_busy          high FETCH..last pixel, low in DONE/IDLE
//   o_frame_done    one-cycle pulse at the end of each frame
//   o_scroll_off    current scroll offset, constant within a frame
//   bus             banner_scan_ctrl_if master: ROM bus and pixel stream
//
// Build option: define BANNER_SCROLL_EN to enable horizontal scrolling
// (offset advances one column every SCROLL_DIV frames). Without it the
// offset is tied to 0 and the pixel index is simply the column.
module banner_scan_ctrl #(
    parameter int WIDTH      = 71,
    parameter int ROWS       = 15,
    parameter int AW         = 5,
    parameter int CW         = 7,
    parameter int SCROLL_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [CW-1:0]     o_scroll_off,
    banner_scan_ctrl_if.master bus
);

    localparam int            IW       = $clog2(WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'(ROWS - 1);
    localparam logic [CW:0]   WIDTH_X  = (CW+1)'(WIDTH);

    if (SCROLL_DIV < 1) begin : g_div_check
        $error("banner_scan_ctrl: SCROLL_DIV must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [AW-1:0]    r_row, w_row_nxt;
    logic [CW-1:0]    r_col, w_col_nxt;
    logic [WIDTH-1:0] r_row_buf;
    logic             w_stream;
    logic             w_xfer;
    logic [CW-1:0]    w_off;
    logic [CW:0]      w_sum;
    logic [CW:0]      w_idx;
    logic [IW-1:0]    w_bit;
    logic             w_pix_on;

    assign w_stream = (r_state == S_STREAM);
    assign w_xfer   = w_stream & bus.pix_ready;

    // State register. The row register doubles as the ROM address: it is
    // what FETCH/LOAD present and it keeps the last row outside them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_STREAM;
            S_STREAM: begin
                if (w_xfer) begin
                    if (r_col == COL_LAST) begin
                        w_col_nxt = '0;
                        if (r_row == ROW_LAST) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_row_nxt   = r_row + AW'(1);
                            w_state_nxt = S_FETCH;
                        end
                    end else begin
                        w_col_nxt = r_col + CW'(1);
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ROM word for the current row lands during LOAD.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row_buf <= '0;
        end else if (r_state == S_LOAD) begin
            r_row_buf <= bus.rom_data;
        end
    end

`ifdef BANNER_SCROLL_EN
    localparam int            FW       = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [FW-1:0] FRM_LAST = FW'(SCROLL_DIV - 1);

    logic [FW-1:0] r_frame_cnt;
    logic [CW-1:0] r_scroll_off;

    // Offset only moves in DONE, so it never changes mid-frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt  <= '0;
            r_scroll_off <= '0;
        end else if (r_state == S_DONE) begin
            if (r_frame_cnt == FRM_LAST) begin
                r_frame_cnt  <= '0;
                r_scroll_off <= (r_scroll_off == COL_LAST) ? '0 : r_scroll_off + CW'(1);
            end else begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
            end
        end
    end

    assign w_off = r_scroll_off;
`else
    assign w_off = '0;
`endif

    // (col + off) mod WIDTH without a divider: both operands are < WIDTH, so
    // one conditional subtract suffices. Column 0 maps to the word's MSB.
    assign w_sum    = {1'b0, r_col} + {1'b0, w_off};
    assign w_idx    = (w_sum >= WIDTH_X) ? (w_sum - WIDTH_X) : w_sum;
    assign w_bit    = IW'(WIDTH_X - (CW+1)'(1) - w_idx);
    assign w_pix_on = r_row_buf[w_bit];

    assign o_busy       = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_STREAM);
    assign o_frame_done = (r_state == S_DONE);
    assign o_scroll_off = w_off;

    assign bus.rom_addr  = r_row;
    assign bus.pix_valid = w_stream;
    assign bus.pix_on    = w_stream & w_pix_on;
    assign bus.pix_row   = w_stream ? r_row : '0;
    assign bus.pix_col   = w_stream ? r_col : '0;

endmodule

// File: tb/tb_banner_scan_ctrl.sv
// Directed bench for banner_scan_ctrl (WIDTH=71, ROWS=15, SCROLL_DIV=1).
// Latency: checks 3-cycle first pixel and 1096-cycle frame_done position.
// Backpressure: stalls the stream at row2 col10 for 5 cycles.
module tb_banner_scan_ctrl;

    localparam int WIDTH = 71;
    localparam int ROWS  = 15;
    localparam int AW    = 5;
    localparam int CW    = 7;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] scroll_off;

    banner_scan_ctrl_if #(.WIDTH(WIDTH), .AW(AW), .CW(CW)) bus ();

    banner_scan_ctrl #(
        .WIDTH(WIDTH), .ROWS(ROWS), .AW(AW), .CW(CW), .SCROLL_DIV(1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_scroll_off (scroll_off),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] rom [0:ROWS-1];
    logic             obs [0:ROWS-1][0:WIDTH-1];
    int               exp_off = 0;
    int               n_tests = 0;
    int               n_fail  = 0;

    // Registered-address banner ROM, one cycle read latency.
    always @(posedge clk) begin
        if (bus.rom_addr < AW'(ROWS)) bus.rom_data <= rom[bus.rom_addr];
        else                          bus.rom_data <= '0;
    end

    function automatic logic exp_pix(input int r, input int c, input int off);
        return rom[r][WIDTH - 1 - ((c + off) % WIDTH)];
    endfunction

    task automatic do_reset;
        start = 1'b0;
        bus.pix_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_off = 0;
        @(posedge clk);
        #1;
    endtask

    // Streams one frame from IDLE, scoreboarding every valid pixel against the
    // ROM model; optionally withholds ready for stall_len cycles at one pixel.
    task automatic run_frame(input int stall_row, input int stall_col, input int stall_len,
                             output int first_vld, output int done_at, output int n_xfer,
                             output int n_err, output int n_busy_bad);
        int er, ec, left;
        bit fin;
        er = 0; ec = 0; left = stall_len; fin = 1'b0;
        first_vld = -1; done_at = -1; n_xfer = 0; n_err = 0; n_busy_bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < WIDTH; c++) obs[r][c] = 1'bx;
        bus.pix_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 1300 && !fin; cyc++) begin
            if (bus.pix_valid && first_vld < 0) first_vld = cyc;
            if (frame_done) begin
                done_at = cyc;
                fin = 1'b1;
                if (busy !== 1'b0) n_busy_bad++;
            end else if (busy !== 1'b1) begin
                n_busy_bad++;
            end
            if (bus.pix_valid) begin
                if (bus.pix_row !== AW'(er) || bus.pix_col !== CW'(ec) ||
                    bus.pix_on !== exp_pix(er, ec, exp_off)) n_err++;
                if (left > 0 && er == stall_row && ec == stall_col) begin
                    bus.pix_ready = 1'b0;
                    left--;
                end else begin
                    bus.pix_ready = 1'b1;
                    obs[er][ec] = bus.pix_on;
                    n_xfer++;
                    if (ec == WIDTH - 1) begin ec = 0; er++; end
                    else ec++;
                end
            end
            if (!fin) begin @(posedge clk); #1; end
        end
        bus.pix_ready = 1'b1;
        if (fin) begin
`ifdef BANNER_SCROLL_EN
            exp_off = (exp_off + 1) % WIDTH;
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, frame_done, bus.pix_valid, bus.pix_on} !== 4'b0000 ||
            bus.rom_addr !== '0 || bus.pix_row !== '0 || bus.pix_col !== '0 || scroll_off !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b vld=%b on=%b addr=%0d row=%0d col=%0d off=%0d, want all 0",
                     busy, frame_done, bus.pix_valid, bus.pix_on, bus.rom_addr, bus.pix_row, bus.pix_col, scroll_off);
        end
        rst_n = 1'b1;
        exp_off = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame;
        int fv, da, nx, ne, nb;
        run_frame(-1, -1, 0, fv, da, nx, ne, nb);
        n_tests++;
        if (fv != 3) begin n_fail++; $display("FAIL first_valid_latency: got %0d, want 3", fv); end
        n_tests++;
        if (da != 1096) begin n_fail++; $display("FAIL frame_done_cycle: got %0d, want 1096", da); end
        n_tests++;
        if (nx != 1065) begin n_fail++; $display("FAIL transfer_count: got %0d, want 1065", nx); end
        n_tests++;
        if (ne != 0) begin n_fail++; $display("FAIL frame_stream: got %0d bad pixels, want 0", ne); end
        n_tests++;
        if (nb != 0) begin n_fail++; $display("FAIL busy_window: got %0d bad cycles, want 0", nb); end
        n_tests++;
        if (obs[0][0] !== 1'b0) begin n_fail++; $display("FAIL r0c0_pix: got %b, want 0", obs[0][0]); end
        n_tests++;
        if (obs[0][17] !== 1'b1) begin n_fail++; $display("FAIL r0c17_pix: got %b, want 1", obs[0][17]); end
        n_tests++;
        if (obs[3][0] !== 1'b1) begin n_fail++; $display("FAIL r3c0_pix: got %b, want 1", obs[3][0]); end
        n_tests++;
        if (bus.rom_addr !== AW'(14) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_frame: addr=%0d busy=%b, want addr=14 busy=0", bus.rom_addr, busy);
        end
    endtask

    task automatic test_backpressure;
        int fv, da, nx, ne, nb;
        run_frame(2, 10, 5, fv, da, nx, ne, nb);
        n_tests++;
        if (ne != 0) begin n_fail++; $display("FAIL stall_stream: got %0d bad pixels, want 0", ne); end
        n_tests++;
        if (nx != 1065) begin n_fail++; $display("FAIL stall_transfers: got %0d, want 1065", nx); end
        n_tests++;
        if (da != 1101) begin n_fail++; $display("FAIL stall_done_cycle: got %0d, want 1101", da); end
    endtask

    task automatic test_start_held_and_reset;
        int er, ec, bad, fv, da, nx, ne, nb;
        bit hit;
        er = 0; ec = 0; bad = 0; hit = 1'b0;
        bus.pix_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 600 && !hit; cyc++) begin
            if (frame_done) bad++;
            if (bus.pix_valid) begin
                if (bus.pix_row !== AW'(er) || bus.pix_col !== CW'(ec) ||
                    bus.pix_on !== exp_pix(er, ec, exp_off)) bad++;
                if (er == 5) hit = 1'b1;
                else if (ec == WIDTH - 1) begin ec = 0; er++; end
                else ec++;
            end
            if (!hit) begin @(posedge clk); #1; end
        end
        n_tests++;
        if (!hit || bad != 0) begin
            n_fail++;
            $display("FAIL start_held_stream: reached_row5=%0d bad=%0d, want 1 and 0", hit, bad);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, frame_done, bus.pix_valid, bus.pix_on} !== 4'b0000 ||
            bus.rom_addr !== '0 || bus.pix_row !== '0 || bus.pix_col !== '0 || scroll_off !== '0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b vld=%b on=%b addr=%0d row=%0d col=%0d off=%0d, want all 0",
                     busy, frame_done, bus.pix_valid, bus.pix_on, bus.rom_addr, bus.pix_row, bus.pix_col, scroll_off);
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_off = 0;
        bad = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (frame_done || busy || bus.pix_valid) bad++;
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL abandoned_frame: got %0d active cycles, want 0", bad); end
        run_frame(-1, -1, 0, fv, da, nx, ne, nb);
        n_tests++;
        if (ne != 0 || fv != 3 || da != 1096) begin
            n_fail++;
            $display("FAIL restart_frame: bad=%0d first=%0d done=%0d, want 0/3/1096", ne, fv, da);
        end
    endtask

`ifdef BANNER_SCROLL_EN
    task automatic test_scroll;
        int fv, da, nx, ne, nb, tot;
        do_reset();
        run_frame(-1, -1, 0, fv, da, nx, ne, nb);
        n_tests++;
        if (scroll_off !== CW'(1)) begin n_fail++; $display("FAIL scroll_after_1: got %0d, want 1", scroll_off); end
        run_frame(-1, -1, 0, fv, da, nx, ne, nb);
        n_tests++;
        if (obs[3][0] !== 1'b1 || obs[3][1] !== 1'b0 || ne != 0) begin
            n_fail++;
            $display("FAIL scroll1_pixels: r3c0=%b r3c1=%b bad=%0d, want 1/0/0", obs[3][0], obs[3][1], ne);
        end
        tot = 0;
        for (int f = 3; f <= 70; f++) begin
            run_frame(-1, -1, 0, fv, da, nx, ne, nb);
            tot += ne;
            if (da != 1096) tot++;
        end
        n_tests++;
        if (scroll_off !== CW'(70)) begin n_fail++; $display("FAIL scroll_after_70: got %0d, want 70", scroll_off); end
        run_frame(-1, -1, 0, fv, da, nx, ne, nb);
        tot += ne;
        n_tests++;
        if (scroll_off !== CW'(0)) begin n_fail++; $display("FAIL scroll_wrap_71: got %0d, want 0", scroll_off); end
        n_tests++;
        if (tot != 0) begin n_fail++; $display("FAIL scroll_frames: got %0d bad, want 0", tot); end
    endtask
`else
    task automatic test_no_scroll;
        int fv, da, nx, ne, nb;
        do_reset();
        for (int f = 1; f <= 3; f++) begin
            run_frame(-1, -1, 0, fv, da, nx, ne, nb);
            n_tests++;
            if (scroll_off !== '0 || obs[3][1] !== 1'b1 || ne != 0) begin
                n_fail++;
                $display("FAIL noscroll_frame%0d: off=%0d r3c1=%b bad=%0d, want 0/1/0", f, scroll_off, obs[3][1], ne);
            end
        end
    endtask
`endif

    initial begin
        for (int r = 0; r < ROWS; r++)
            for (int b = 0; b < WIDTH; b++) rom[r][b] = (((b * 5 + r * 3) % 7) < 3);
        rom[0][70] = 1'b0;
        rom[0][53] = 1'b1;
        rom[3][70] = 1'b1;
        rom[3][69] = 1'b1;
        rom[3][68] = 1'b0;
        bus.pix_ready = 1'b1;

        test_reset();
        test_frame();
        test_backpressure();
        test_start_held_and_reset();
`ifdef BANNER_SCROLL_EN
        test_scroll();
`else
        test_no_scroll();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
